// File: rtl/my_mod.sv
// 9-bit pipelined shift/logic/arithmetic unit with compile-time shift distance X
// and Y register stages between input accept and out_valid.
module my_mod #(
  parameter int unsigned X = 1,
  parameter int unsigned Y = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] op,
  input  logic [8:0] foo,
  input  logic [8:0] bar,
  output logic       out_valid,
  output logic [8:0] result,
  output logic       parity,
  output logic       carry
);

  generate
    if (X > 8 || Y < 1 || Y > 4) begin : g_bad_param
      $error("my_mod: illegal parameters X=%0d Y=%0d", X, Y);
    end
  endgenerate

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_SHL  = 3'd1,
    OP_LSR  = 3'd2,
    OP_ASR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } op_e;

  logic [17:0]        shl_full;
  logic [17:0]        lsr_full;
  logic signed [17:0] asr_full;
  logic [9:0]         sum_w;
  logic [9:0]         diff_w;
  logic [8:0]         alu_res;
  logic               alu_carry;

  // Shifts run on a double-width word so the shifted-out bits land in the spare half.
  always_comb begin
    shl_full  = {9'b0, foo} << X;
    lsr_full  = {foo, 9'b0} >> X;
    asr_full  = $signed({foo, 9'b0}) >>> X;
    sum_w     = {1'b0, foo} + {1'b0, bar};
    diff_w    = {1'b0, foo} - {1'b0, bar};
    alu_res   = foo;
    alu_carry = 1'b0;
    case (op)
      OP_PASS: begin
        alu_res   = foo;
        alu_carry = 1'b0;
      end
      OP_SHL: begin
        alu_res   = shl_full[8:0];
        alu_carry = |shl_full[17:9];
      end
      OP_LSR: begin
        alu_res   = lsr_full[17:9];
        alu_carry = |lsr_full[8:0];
      end
      OP_ASR: begin
        alu_res   = asr_full[17:9];
        alu_carry = |asr_full[8:0];
      end
      OP_XOR: begin
        alu_res   = foo ^ bar;
        alu_carry = 1'b0;
      end
      OP_XNOR: begin
        alu_res   = ~(foo ^ bar);
        alu_carry = 1'b0;
      end
      OP_ADD: begin
        alu_res   = sum_w[8:0];
        alu_carry = sum_w[9];
      end
      OP_SUB: begin
        alu_res   = diff_w[8:0];
        alu_carry = diff_w[9];
      end
      default: begin
        alu_res   = foo;
        alu_carry = 1'b0;
      end
    endcase
  end

  logic [Y-1:0] valid_q, valid_d;
  logic [8:0]   res_q   [Y];
  logic [8:0]   res_d   [Y];
  logic         carry_q [Y];
  logic         carry_d [Y];

  // Stage data only moves with a valid token, so bubbles leave the last result held.
  always_comb begin
    valid_d    = valid_q;
    res_d      = res_q;
    carry_d    = carry_q;
    valid_d[0] = in_valid;
    if (in_valid) begin
      res_d[0]   = alu_res;
      carry_d[0] = alu_carry;
    end
    for (int i = 1; i < Y; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        res_d[i]   = res_q[i-1];
        carry_d[i] = carry_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < Y; i++) begin
        res_q[i]   <= '0;
        carry_q[i] <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign out_valid = valid_q[Y-1];
  assign result    = res_q[Y-1];
  assign carry     = carry_q[Y-1];
  assign parity    = ^res_q[Y-1];

endmodule

// File: tb/tb_my_mod.sv
// Bench for my_mod: three instances (Y=2/X=1, Y=1/X=3, Y=4/X=0) share one input
// stream and are checked against a due-time scoreboard built from the op rules.
module tb_my_mod;

  localparam int YS [3] = '{2, 1, 4};
  localparam int XS [3] = '{1, 3, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] op;
  logic [8:0] foo;
  logic [8:0] bar;

  logic       ov    [3];
  logic [8:0] res_o [3];
  logic       par_o [3];
  logic       cy_o  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  my_mod #(.X(1), .Y(2)) dut_y2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .foo(foo), .bar(bar),
    .out_valid(ov[0]), .result(res_o[0]), .parity(par_o[0]), .carry(cy_o[0])
  );

  my_mod #(.X(3), .Y(1)) dut_y1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .foo(foo), .bar(bar),
    .out_valid(ov[1]), .result(res_o[1]), .parity(par_o[1]), .carry(cy_o[1])
  );

  my_mod #(.X(0), .Y(4)) dut_y4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .foo(foo), .bar(bar),
    .out_valid(ov[2]), .result(res_o[2]), .parity(par_o[2]), .carry(cy_o[2])
  );

  typedef struct {
    int         n;
    logic [2:0] op;
    int         a;
    int         b;
  } acc_t;

  acc_t       acc [$];
  int         rd    [3];
  int         cyc = 0;
  logic       exp_v [3];
  logic [8:0] exp_r [3];
  logic       exp_c [3];

  // Reference behaviour straight from the op table, in integer arithmetic.
  function automatic logic [9:0] ref_op(input logic [2:0] o, input int a, input int b, input int x);
    int p, full, sa, q, r;
    logic c;
    p = 1 << x;
    r = a;
    c = 1'b0;
    case (o)
      3'd0: begin r = a; c = 1'b0; end
      3'd1: begin full = a * p; r = full % 512; c = (full >= 512); end
      3'd2: begin r = a / p; c = ((a % p) != 0); end
      3'd3: begin
        sa = (a >= 256) ? a - 512 : a;
        q  = (sa - (((sa % p) + p) % p)) / p;
        r  = (q + 512) % 512;
        c  = ((a % p) != 0);
      end
      3'd4: begin r = a ^ b; c = 1'b0; end
      3'd5: begin r = 511 - (a ^ b); c = 1'b0; end
      3'd6: begin r = (a + b) % 512; c = ((a + b) >= 512); end
      default: begin r = (a - b + 512) % 512; c = (a < b); end
    endcase
    return {c, r[8:0]};
  endfunction

  function automatic logic parity_of(input logic [8:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  // One clock: record what the edge accepted, work out what each instance owes, sample at negedge.
  task automatic tick();
    acc_t e;
    @(posedge clk);
    cyc++;
    if (rst_n && in_valid) begin
      e.n  = cyc;
      e.op = op;
      e.a  = int'(foo);
      e.b  = int'(bar);
      acc.push_back(e);
    end
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        exp_v[d] = 1'b0;
        exp_r[d] = '0;
        exp_c[d] = 1'b0;
        rd[d]    = acc.size();
      end else if (rd[d] < acc.size() && acc[rd[d]].n + YS[d] - 1 == cyc) begin
        {exp_c[d], exp_r[d]} = ref_op(acc[rd[d]].op, acc[rd[d]].a, acc[rd[d]].b, XS[d]);
        exp_v[d] = 1'b1;
        rd[d]++;
      end else begin
        exp_v[d] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [8:0] a, input logic [8:0] b);
    in_valid = v;
    op       = o;
    foo      = a;
    bar      = b;
  endtask

  task automatic run_one(input logic [2:0] o, input logic [8:0] a, input logic [8:0] b);
    drive(1'b1, o, a, b);
    tick();
    drive(1'b0, 3'd0, 9'h0, 9'h0);
    tick();
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 9'h0, 9'h0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 3'd0, 9'h1AB, 9'h000);
    repeat (2) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if ({ov[d], res_o[d], cy_o[d], par_o[d]} !== 12'h000) begin
          n_err++;
          $display("[TB] FAIL reset_outputs d%0d: got v=%b r=%h c=%b p=%b want all zero",
                   d, ov[d], res_o[d], cy_o[d], par_o[d]);
        end
      end
    end
    rst_n = 1'b1;
    drive(1'b1, 3'd0, 9'h0A5, 9'h000);
    tick();
    drive(1'b0, 3'd0, 9'h0, 9'h0);
    n_cmp++;
    if (ov[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_release_early: got out_valid=%b want 0", ov[0]);
    end
    n_cmp++;
    if (ov[1] !== 1'b1 || res_o[1] !== 9'h0A5) begin
      n_err++;
      $display("[TB] FAIL reset_release_y1: got v=%b r=%h want v=1 r=0a5", ov[1], res_o[1]);
    end
    tick();
    n_cmp++;
    if (ov[0] !== 1'b1 || res_o[0] !== 9'h0A5) begin
      n_err++;
      $display("[TB] FAIL reset_release_y2: got v=%b r=%h want v=1 r=0a5", ov[0], res_o[0]);
    end
    n_cmp++;
    if (ov[1] !== 1'b0 || res_o[1] !== 9'h0A5) begin
      n_err++;
      $display("[TB] FAIL reset_hold_y1: got v=%b r=%h want v=0 r=0a5", ov[1], res_o[1]);
    end
    idle(4);
  endtask

  task automatic test_shift();
    run_one(3'd1, 9'h101, 9'h1FF);
    n_cmp++;
    if (ov[0] !== 1'b1 || res_o[0] !== 9'h002 || cy_o[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL shl: got v=%b r=%h c=%b want v=1 r=002 c=1", ov[0], res_o[0], cy_o[0]);
    end
    run_one(3'd2, 9'h003, 9'h000);
    n_cmp++;
    if (ov[0] !== 1'b1 || res_o[0] !== 9'h001 || cy_o[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL lsr: got v=%b r=%h c=%b want v=1 r=001 c=1", ov[0], res_o[0], cy_o[0]);
    end
    run_one(3'd3, 9'h100, 9'h000);
    n_cmp++;
    if (ov[0] !== 1'b1 || res_o[0] !== 9'h180 || cy_o[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL asr: got v=%b r=%h c=%b want v=1 r=180 c=0", ov[0], res_o[0], cy_o[0]);
    end
    idle(4);
  endtask

  task automatic test_arith();
    run_one(3'd6, 9'h1FF, 9'h002);
    n_cmp++;
    if (res_o[0] !== 9'h001 || cy_o[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL add_wrap: got r=%h c=%b want r=001 c=1", res_o[0], cy_o[0]);
    end
    run_one(3'd7, 9'h005, 9'h006);
    n_cmp++;
    if (res_o[0] !== 9'h1FF || cy_o[0] !== 1'b1 || par_o[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL sub_borrow: got r=%h c=%b p=%b want r=1ff c=1 p=1", res_o[0], cy_o[0], par_o[0]);
    end
    idle(4);
  endtask

  task automatic test_logic();
    run_one(3'd4, 9'h0F0, 9'h0FF);
    n_cmp++;
    if (res_o[0] !== 9'h00F || par_o[0] !== 1'b0 || cy_o[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL xor: got r=%h p=%b c=%b want r=00f p=0 c=0", res_o[0], par_o[0], cy_o[0]);
    end
    run_one(3'd5, 9'h0F0, 9'h0FF);
    n_cmp++;
    if (res_o[0] !== 9'h1F0 || par_o[0] !== 1'b1 || cy_o[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL xnor: got r=%h p=%b c=%b want r=1f0 p=1 c=0", res_o[0], par_o[0], cy_o[0]);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [8:0] vals [4];
    logic       pat  [4];
    int         j;
    logic       want_v;
    vals = '{9'd1, 9'd2, 9'd0, 9'd3};
    pat  = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(pat[k], 3'd0, vals[k], 9'h0);
      else       drive(1'b0, 3'd0, 9'h0, 9'h0);
      tick();
      for (int d = 0; d < 3; d++) begin
        j      = k - (YS[d] - 1);
        want_v = (j >= 0 && j <= 3) ? pat[j] : 1'b0;
        n_cmp++;
        if (ov[d] !== want_v) begin
          n_err++;
          $display("[TB] FAIL b2b_valid d%0d slot %0d: got %b want %b", d, k, ov[d], want_v);
        end
        if (want_v) begin
          n_cmp++;
          if (res_o[d] !== vals[j]) begin
            n_err++;
            $display("[TB] FAIL b2b_result d%0d slot %0d: got %h want %h", d, k, res_o[d], vals[j]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd0, 9'h011, 9'h0);
    tick();
    drive(1'b1, 3'd6, 9'h022, 9'h033);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 9'h0, 9'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (ov[d] !== 1'b0 || res_o[d] !== 9'h000) begin
          n_err++;
          $display("[TB] FAIL midreset_flush d%0d cycle %0d: got v=%b r=%h want v=0 r=000",
                   d, k, ov[d], res_o[d]);
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 0) drive(1'b1, 3'd0, 9'h077, 9'h0);
      else        drive(1'b0, 3'd0, 9'h0, 9'h0);
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (ov[d] !== (k == YS[d] - 1)) begin
          n_err++;
          $display("[TB] FAIL midreset_latency d%0d cycle %0d: got v=%b want %b", d, k, ov[d], (k == YS[d] - 1));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (ov[d] !== exp_v[d]) begin
          n_err++;
          $display("[TB] FAIL rand_valid d%0d cyc %0d: got %b want %b", d, cyc, ov[d], exp_v[d]);
        end
        n_cmp++;
        if (res_o[d] !== exp_r[d]) begin
          n_err++;
          $display("[TB] FAIL rand_result d%0d cyc %0d: got %h want %h", d, cyc, res_o[d], exp_r[d]);
        end
        n_cmp++;
        if (cy_o[d] !== exp_c[d]) begin
          n_err++;
          $display("[TB] FAIL rand_carry d%0d cyc %0d: got %b want %b", d, cyc, cy_o[d], exp_c[d]);
        end
        n_cmp++;
        if (par_o[d] !== parity_of(exp_r[d])) begin
          n_err++;
          $display("[TB] FAIL rand_parity d%0d cyc %0d: got %b want %b", d, cyc, par_o[d], parity_of(exp_r[d]));
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 9'h0, 9'h0);
    for (int d = 0; d < 3; d++) begin
      rd[d]    = 0;
      exp_v[d] = 1'b0;
      exp_r[d] = '0;
      exp_c[d] = 1'b0;
    end
    test_reset();
    test_shift();
    test_arith();
    test_logic();
    idle(4);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
